// File: rtl/bus_store_monitor_if.sv
// rtl/bus_store_monitor_if.sv - store bus and log read port bundle for bus_store_monitor
interface bus_store_monitor_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          MemWrite;
  logic [31:0]   Adr;
  logic [31:0]   WriteData;
  logic          rd_ready;
  logic          rd_valid;
  logic [31:0]   rd_adr;
  logic [31:0]   rd_data;
  logic [CW-1:0] count;
  logic          overflow;
  logic [31:0]   store_count;
  logic          done;
  logic          pass;
  logic          timeout;

  modport master (
    output MemWrite, Adr, WriteData, rd_ready,
    input  rd_valid, rd_adr, rd_data, count, overflow, store_count, done, pass, timeout
  );

  modport slave (
    input  MemWrite, Adr, WriteData, rd_ready,
    output rd_valid, rd_adr, rd_data, count, overflow, store_count, done, pass, timeout
  );
endinterface

// File: rtl/bus_store_monitor.sv
// rtl/bus_store_monitor.sv - store logger FIFO with completion and hang detection
module bus_store_monitor #(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] PASS_ADR  = 32'd100,
  parameter logic [31:0] PASS_DATA = 32'd7,
  parameter int          TIMEOUT   = 1000
) (
  input  logic                clk,
  input  logic                reset,
  bus_store_monitor_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_PASS = 2'd1,
    S_TOUT = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic [31:0]   adr_mem  [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [15:0]   idle_q;
  logic [31:0]   store_count_q;
  logic          overflow_q;

  logic store;
  logic full;
  logic valid;
  logic pop;
  logic push;
  logic drop;
  logic is_pass;

  // Stores only count while running; a full FIFO still takes a push if the head leaves this cycle.
  assign store   = bus.MemWrite && (state_q == S_RUN);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign valid   = (count_q != '0);
  assign pop     = valid && bus.rd_ready;
  assign push    = store && (!full || pop);
  assign drop    = store && full && !pop;
  assign is_pass = (bus.Adr == PASS_ADR) && (bus.WriteData == PASS_DATA);

  // Next state: completion store wins; otherwise the idle count reaching TIMEOUT hangs.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (store) begin
          if (is_pass) state_d = S_PASS;
        end else if (idle_q + 16'd1 == 16'(TIMEOUT)) begin
          state_d = S_TOUT;
        end
      end
      default: state_d = state_q;
    endcase
  end

  // State register; PASS and TOUT hold until reset.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_RUN;
    else       state_q <= state_d;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage; contents are invisible once pointers reset, so no clear is needed.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      adr_mem[wr_ptr]  <= bus.Adr;
      data_mem[wr_ptr] <= bus.WriteData;
    end
  end

  // Store counter, sticky overflow and idle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      store_count_q <= '0;
      overflow_q    <= 1'b0;
      idle_q        <= '0;
    end else begin
      if (store) store_count_q <= store_count_q + 32'd1;
      if (drop)  overflow_q    <= 1'b1;
      if (store)                 idle_q <= '0;
      else if (state_q == S_RUN) idle_q <= idle_q + 16'd1;
    end
  end

  assign bus.rd_valid    = valid;
  assign bus.rd_adr      = valid ? adr_mem[rd_ptr]  : 32'd0;
  assign bus.rd_data     = valid ? data_mem[rd_ptr] : 32'd0;
  assign bus.count       = count_q;
  assign bus.overflow    = overflow_q;
  assign bus.store_count = store_count_q;
  assign bus.done        = (state_q != S_RUN);
  assign bus.pass        = (state_q == S_PASS);
  assign bus.timeout     = (state_q == S_TOUT);
endmodule

// File: tb/tb_bus_store_monitor.sv
// tb/tb_bus_store_monitor.sv - randomized and directed bench for bus_store_monitor
module tb_bus_store_monitor;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 1000;

  logic clk;
  logic reset;

  bus_store_monitor_if #(.DEPTH(DEPTH)) bus ();

  bus_store_monitor #(
    .DEPTH(DEPTH), .PASS_ADR(32'd100), .PASS_DATA(32'd7), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: log as a queue of {adr,data}; status as plain counters and flags.
  logic [63:0] m_q[$];
  int          m_state;  // 0 running, 1 passed, 2 hung
  int          m_idle;
  logic [31:0] m_sc;
  bit          m_ov;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_edge(input bit rst, input bit mw, input logic [31:0] a,
                            input logic [31:0] d, input bit rdy);
    bit popped;
    if (rst) begin
      m_q.delete();
      m_state = 0; m_idle = 0; m_sc = 0; m_ov = 0;
      return;
    end
    popped = (m_q.size() != 0) && rdy;
    if (popped) void'(m_q.pop_front());
    if (mw && m_state == 0) begin
      if (m_q.size() < DEPTH) m_q.push_back({a, d});
      else m_ov = 1;
      m_sc = m_sc + 1;
      m_idle = 0;
      if (a == 32'd100 && d == 32'd7) m_state = 1;
    end else if (m_state == 0) begin
      m_idle++;
      if (m_idle == TIMEOUT) m_state = 2;
    end
  endtask

  task automatic compare_all();
    bit v;
    v = (m_q.size() != 0);
    check("rd_valid", 32'(bus.rd_valid), 32'(v));
    check("rd_adr", bus.rd_adr, v ? m_q[0][63:32] : 32'd0);
    check("rd_data", bus.rd_data, v ? m_q[0][31:0] : 32'd0);
    check("count", 32'(bus.count), 32'(m_q.size()));
    check("overflow", 32'(bus.overflow), 32'(m_ov));
    check("store_count", bus.store_count, m_sc);
    check("done", 32'(bus.done), 32'(m_state != 0));
    check("pass", 32'(bus.pass), 32'(m_state == 1));
    check("timeout", 32'(bus.timeout), 32'(m_state == 2));
  endtask

  task automatic step(input bit rst, input bit mw, input logic [31:0] a,
                      input logic [31:0] d, input bit rdy);
    reset         = rst;
    bus.MemWrite  = mw;
    bus.Adr       = a;
    bus.WriteData = d;
    bus.rd_ready  = rdy;
    model_edge(rst, mw, a, d, rdy);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.MemWrite = 0; bus.Adr = 0; bus.WriteData = 0; bus.rd_ready = 0;
    m_state = 0; m_idle = 0; m_sc = 0; m_ov = 0;

    // Reset then pure idle: hang flagged exactly TIMEOUT cycles after release.
    do_reset();
    check("reset_done", 32'(bus.done), 32'd0);
    for (int i = 0; i < TIMEOUT - 1; i++) step(0, 0, 0, 0, 0);
    check("pre_timeout", 32'(bus.timeout), 32'd0);
    step(0, 0, 0, 0, 0);
    check("timeout_edge", 32'(bus.timeout), 32'd1);
    check("timeout_done", 32'(bus.done), 32'd1);
    step(0, 1, 32'h60, 32'h1, 0);
    check("tout_ignores_store", bus.store_count, 32'd0);

    // Two stores, then drain.
    do_reset();
    step(0, 1, 32'h50, 32'h11, 0);
    step(0, 1, 32'h54, 32'h22, 0);
    check("two_count", 32'(bus.count), 32'd2);
    check("two_head", bus.rd_adr, 32'h50);
    step(0, 0, 0, 0, 1);
    check("second_head", bus.rd_data, 32'h22);
    step(0, 0, 0, 0, 1);
    check("drained", 32'(bus.rd_valid), 32'd0);

    // Ten stores into an eight-deep log, then drain.
    do_reset();
    for (int i = 0; i < 10; i++) step(0, 1, 32'h200 + 32'(4 * i), 32'(i), 0);
    check("ovf_count", 32'(bus.count), 32'd8);
    check("ovf_flag", 32'(bus.overflow), 32'd1);
    check("ovf_sc", bus.store_count, 32'd10);
    for (int i = 0; i < 8; i++) begin
      check("ovf_drain_order", bus.rd_data, 32'(i));
      step(0, 0, 0, 0, 1);
    end

    // Completion store, then a repeat that must be ignored.
    do_reset();
    step(0, 1, 32'd100, 32'd7, 0);
    check("pass_flag", 32'(bus.pass), 32'd1);
    check("pass_entry", bus.rd_adr, 32'd100);
    step(0, 1, 32'd100, 32'd7, 0);
    check("pass_repeat_sc", bus.store_count, 32'd1);
    check("pass_repeat_cnt", 32'(bus.count), 32'd1);

    // Full log with simultaneous push and pop.
    do_reset();
    for (int i = 0; i < 8; i++) step(0, 1, 32'h300, 32'(i), 0);
    step(0, 1, 32'h3ff, 32'hab, 1);
    check("fullpp_count", 32'(bus.count), 32'd8);
    check("fullpp_ovf", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 1);
    check("fullpp_last", bus.rd_data, 32'hab);
    step(0, 0, 0, 0, 1);

    // Reset pulse while passed with three entries.
    do_reset();
    step(0, 1, 32'd1, 32'd1, 0);
    step(0, 1, 32'd2, 32'd2, 0);
    step(0, 1, 32'd100, 32'd7, 0);
    check("pre_rst_count", 32'(bus.count), 32'd3);
    step(1, 1, 32'd100, 32'd7, 0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_pass", 32'(bus.pass), 32'd0);
    step(0, 1, 32'd104, 32'd5, 0);
    check("post_rst_entry", bus.rd_adr, 32'd104);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 4000; i++) begin
      bit          r, mw, rdy;
      logic [31:0] a, d;
      r   = ($urandom_range(0, 99) < 2);
      mw  = ($urandom_range(0, 2) != 0);
      rdy = ($urandom_range(0, 1) != 0);
      a   = ($urandom_range(0, 3) == 0) ? 32'd100 : $urandom;
      d   = ($urandom_range(0, 3) == 0) ? 32'd7 : $urandom;
      step(r, mw, a, d, rdy);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
